// File: rtl/divider_unit.sv
// Iterative restoring divider for RV32M-style DIV/DIVU/REM/REMU.
// Computes one quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'b00
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'b01
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'b10
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'b11
`endif

module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     div_valid,
    input  logic [`DIV_OP_WIDTH-1:0] DIVop,
    input  logic [WIDTH-1:0]         dividend,
    input  logic [WIDTH-1:0]         divisor,
    output logic [WIDTH-1:0]         div_result,
    output logic                     div_ready,
    output logic                     busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              is_rem_p0, neg_q_p0, neg_r_p0;
    logic [WIDTH-1:0]  dvs_p0, quo_p0, rem_p0;

    logic                     in_signed, in_rem, in_div0, in_ovf;
    logic signed [WIDTH-1:0]  dnd_s, dvs_s;
    logic [WIDTH:0]           rem_sh, trial;
    logic [WIDTH-1:0]         rem_nx, quo_nx;

    // Two's-complement negation of the most negative value yields 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic use_sign);
        if (use_sign && v[WIDTH-1])
            return -v;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] special_result(input logic div0, input logic rem,
                                                       input logic [WIDTH-1:0] dnd);
        if (div0)
            return rem ? dnd : ALL_ONES;
        return rem ? '0 : dnd;
    endfunction

    assign dnd_s = dividend;
    assign dvs_s = divisor;

    always_comb begin
        in_signed = 1'b0;
        in_rem    = 1'b0;
        case (DIVop)
            `DIV_OP_DIV:  in_signed = 1'b1;
            `DIV_OP_REM:  begin in_signed = 1'b1; in_rem = 1'b1; end
            `DIV_OP_REMU: in_rem = 1'b1;
            default:      ;
        endcase
    end

    assign in_div0 = (divisor == '0);
    assign in_ovf  = in_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);

    assign rem_sh = {rem_p0, quo_p0[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_p0};
    assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx = {quo_p0[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_ready  <= 1'b0;
            busy       <= 1'b0;
            div_result <= '0;
            count      <= '0;
        end else begin
            div_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_valid) begin
                        busy <= 1'b1;
                        if (in_div0 || in_ovf) begin
                            div_result <= special_result(in_div0, in_rem, dividend);
                            state      <= DONE;
                        end else begin
                            count <= CNT_W'(WIDTH-1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (count == '0) begin
                        div_result <= is_rem_p0 ? apply_sign(rem_nx, neg_r_p0)
                                                : apply_sign(quo_nx, neg_q_p0);
                        state      <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    div_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand/iteration registers: loaded on acceptance, advanced once per CALC cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && div_valid) begin
            is_rem_p0 <= in_rem;
            neg_q_p0  <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_p0  <= in_signed && dividend[WIDTH-1];
            dvs_p0    <= magnitude(dvs_s, in_signed);
            quo_p0    <= magnitude(dnd_s, in_signed);
            rem_p0    <= '0;
        end else if (state == CALC) begin
            quo_p0 <= quo_nx;
            rem_p0 <= rem_nx;
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: a driver queues expected results/completion edges,
// a negedge monitor pops and compares whenever div_ready is seen.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'b00
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'b01
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'b10
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'b11
`endif

module tb_divider_unit;
    localparam int W = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     div_valid;
    logic [`DIV_OP_WIDTH-1:0] DIVop;
    logic [W-1:0]             dividend, divisor;
    logic [W-1:0]             div_result;
    logic                     div_ready, busy;

    divider_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .div_valid(div_valid), .DIVop(DIVop),
        .dividend(dividend), .divisor(divisor),
        .div_result(div_result), .div_ready(div_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           edge_n;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (div_ready) begin
            chk("ready_back_to_back", {31'd0, prev_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("spurious_ready", {31'd0, div_ready}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", div_result, e.res);
                chk("ready_edge", edge_cnt, e.edge_n);
            end
        end
        prev_ready = div_ready;
    end

    // Called at a negedge with the unit idle; returns at the negedge where busy has dropped.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit fast);
        int n;
        sb_q.push_back('{exp, edge_cnt + 1 + (fast ? 1 : W + 1)});
        DIVop = op; dividend = a; divisor = b; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        DIVop = `DIV_OP_DIV; dividend = $urandom; divisor = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, fast ? 1 : W + 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; div_valid = 1'b0; DIVop = '0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, div_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", div_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(`DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 1'b0);
        issue(`DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 1'b0);
        issue(`DIV_OP_REMU, 32'hFFFF_FFF9, 32'd2,  32'h0000_0001, 1'b0);
        issue(`DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0);

        issue(`DIV_OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(`DIV_OP_DIV,  32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(`DIV_OP_REM,  32'd100, 32'd0, 32'h0000_0064, 1'b1);

        issue(`DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue(`DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(`DIV_OP_DIV, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0);

        // Abort mid-calculation: no expectation is queued, so any ready is spurious.
        DIVop = `DIV_OP_DIVU; dividend = 32'd5000; divisor = 32'd3; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, div_ready}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        issue(`DIV_OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0);

        // Operands change while busy, valid held high into a back-to-back second request.
        sb_q.push_back('{32'hFFFF_FFFD, edge_cnt + 1 + W + 1});
        sb_q.push_back('{32'd33, edge_cnt + 1 + (W + 2) + (W + 1)});
        DIVop = `DIV_OP_DIV; dividend = 32'hFFFF_FFF9; divisor = 32'd2; div_valid = 1'b1;
        @(negedge clk);
        DIVop = `DIV_OP_DIVU; dividend = 32'd100; divisor = 32'd3;
        n = 0;
        while (!div_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first_ready", {31'd0, div_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        div_valid = 1'b0;
        dividend = 32'hDEAD_BEEF; divisor = 32'd9;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", n, W + 1);
        repeat (6) @(negedge clk);
        chk("result_hold", div_result, 32'd33);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
